uart_trans_cfg: RTL and testbench
=================================

# uart_trans_cfg

Parametrised, run-time configurable UART transmitter; successor to the fixed 8N1 transmitter in the processor's UART peripheral. It serialises one word per request with programmable data length (5-8), optional even/odd parity and 1 or 2 stop bits. It supports back-to-back frames with no idle gap and pulses a read strobe to the TX FIFO. It sits between the UART TX FIFO and the `tx` pin and is driven by the shared baud-rate tick generator.

## Interface
- `DATA_BITS`, 8: maximum data length and width of `din`; must be 8 for the full `data_len` range.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; must be at least 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `s_tick`  in  1  one-cycle baud oversample tick.
- `tx_start`  in  1  request to send `din`; level, sampled when accepting.
- `din`  in  DATA_BITS  word to send; LSB first.
- `data_len`  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx`  out  1  serial line; idle high.
- `tx_ack`  out  1  one-cycle pulse: word accepted, pop FIFO.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done_tick`  out  1  one-cycle pulse at end of last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Counters: tick counter `s` (width clog2(OVERSAMPLE)), bit counter `n` (3 bits), shift register `b`.
- Acceptance: at a rising edge with state IDLE (or the final STOP edge, see below) and `tx_start`=1:
  - `din`, `data_len`, `parity_mode` and `stop2` are latched into shadow registers.
  - State goes to START, `s`=0.
  - Input changes mid-frame have no effect.
- Bit timing: in START, DATA, PARITY and STOP, each `s_tick` with `s`<OVERSAMPLE-1 increments `s`. An `s_tick` with `s`=OVERSAMPLE-1 clears `s` and ends the bit. Cycles without `s_tick` hold everything.
- START: `tx`=0 for one bit, then DATA with `n`=0.
- DATA: `tx`=`b[0]`. At each bit end `b` shifts right. When `n`=latched length-1, go to PARITY if parity is enabled, else STOP; otherwise `n`++.
- PARITY: `tx` = XOR of the latched data bits, restricted to the configured length, for even; its inverse for odd. Duration one bit, then STOP.
- STOP: `tx`=1 for 1 bit, or 2 bits if `stop2` (`n` counts stop bits). At the final bit end `tx_done_tick`=1:
  - if `tx_start`=1 on that same edge, the new word is accepted directly into START (no idle bit);
  - otherwise go to IDLE.
- `tx_busy` = (state != IDLE).
- Frame length = OVERSAMPLE × (1 + N + P + S) `s_tick`s.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `tx`=1; `tx_ack`, `tx_busy`, `tx_done_tick`=0; `s`, `n`, `b` and shadow registers = 0. Reset has priority and applies mid-frame; `tx` returns high on the next edge.
- All outputs are registered.
- Accept edge E: `tx`=0, `tx_busy`=1 and `tx_ack`=1 from E until E+1; `tx_ack` is low after E+1.
- `tx_done_tick` is high for exactly the one cycle following the final stop-bit edge.
- `tx_start` held high in IDLE produces exactly one acceptance per frame.
- An `s_tick` present in the acceptance cycle is not counted.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity logic are built as described.
- Not defined: PARITY state, parity logic and the latched `parity_mode` are omitted; `parity_mode` is ignored; DATA always goes to STOP; frames are always xN1/xN2.

## Test plan
- Reset, then `s_tick` every cycle, OVERSAMPLE=16, `din`=8'hA5, 8N1: `tx` gives 0,1,0,1,0,0,1,0,1,1, 16 cycles each; `tx_ack` pulses once; `tx_done_tick` pulses 160 cycles after accept.
- `din`=8'hA5, even parity: parity bit 0; odd parity: 1 (macro defined). Macro undefined with `parity_mode`=01: no parity bit, 160-cycle frame.
- `data_len`=10, `din`=8'hFF, `stop2`=1: 7 ones after start, then 32 cycles high, frame 160 cycles; bit 7 never transmitted.
- `tx_start` held high across two frames (8'h55 then 8'h0F): second start bit begins in the cycle after the first frame's final stop-bit edge; two `tx_ack` and two `tx_done_tick` pulses; no idle bit.
- `reset` asserted during DATA bit 3: next cycle `tx`=1, `tx_busy`=0, no `tx_done_tick`; a new request after reset sends a complete frame.
- `s_tick` once every 4 cycles: every bit lasts 64 cycles; changing `din` and `data_len` mid-frame does not alter the frame.

Source files
------------

// File: rtl/uart_trans_cfg.sv
// Run-time configurable UART transmitter: 5-8 data bits, optional parity, 1/2 stop bits.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise parity_mode is ignored.
module uart_trans_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    input  logic [1:0]           data_len,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 tx,
    output logic                 tx_ack,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SLast = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } stateType;

    stateType             state;
    logic [SW-1:0]        sCnt;
    logic [2:0]           nCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [1:0]           lenQ;
    logic                 stop2Q;

    logic bitEnd;
    logic lastData;
    logic finalStop;
    logic accept;

`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] dinQ;
    logic [1:0]           parQ;
    logic                 parityBit;
    logic                 parityOn;

    always_comb begin
        parityBit = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i < int'(lenQ) + 5) begin
                parityBit = parityBit ^ dinQ[i];
            end
        end
        if (parQ == 2'b10) begin
            parityBit = ~parityBit;
        end
    end

    assign parityOn = (parQ == 2'b01) || (parQ == 2'b10);
`else
    logic unusedParityMode;
    assign unusedParityMode = ^parity_mode;
`endif

    assign shiftNext = shiftReg >> 1;
    assign bitEnd    = s_tick && (sCnt == SLast);
    assign lastData  = (nCnt == (3'(lenQ) + 3'd4));
    // nCnt counts completed stop bits, so the last one is at index stop2Q
    assign finalStop = (state == StStop) && bitEnd && (nCnt == {2'b00, stop2Q});
    assign accept    = tx_start && ((state == StIdle) || finalStop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= StIdle;
            sCnt         <= '0;
            nCnt         <= '0;
            shiftReg     <= '0;
            lenQ         <= '0;
            stop2Q       <= 1'b0;
            tx           <= 1'b1;
            tx_ack       <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            dinQ         <= '0;
            parQ         <= '0;
`endif
        end else begin
            tx_ack       <= 1'b0;
            tx_done_tick <= 1'b0;
            if (accept) begin
                state        <= StStart;
                sCnt         <= '0;
                nCnt         <= '0;
                shiftReg     <= din;
                lenQ         <= data_len;
                stop2Q       <= stop2;
                tx           <= 1'b0;
                tx_ack       <= 1'b1;
                tx_busy      <= 1'b1;
                tx_done_tick <= finalStop;
`ifdef UART_TX_PARITY_EN
                dinQ         <= din;
                parQ         <= parity_mode;
`endif
            end else if (finalStop) begin
                state        <= StIdle;
                sCnt         <= '0;
                nCnt         <= '0;
                tx           <= 1'b1;
                tx_busy      <= 1'b0;
                tx_done_tick <= 1'b1;
            end else if (s_tick && (state != StIdle)) begin
                if (!bitEnd) begin
                    sCnt <= sCnt + 1'b1;
                end else begin
                    sCnt <= '0;
                    case (state)
                        StStart: begin
                            state <= StData;
                            nCnt  <= '0;
                            tx    <= shiftReg[0];
                        end
                        StData: begin
                            shiftReg <= shiftNext;
                            if (lastData) begin
                                nCnt <= '0;
`ifdef UART_TX_PARITY_EN
                                if (parityOn) begin
                                    state <= StParity;
                                    tx    <= parityBit;
                                end else begin
                                    state <= StStop;
                                    tx    <= 1'b1;
                                end
`else
                                state <= StStop;
                                tx    <= 1'b1;
`endif
                            end else begin
                                nCnt <= nCnt + 3'd1;
                                tx   <= shiftNext[0];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        StParity: begin
                            state <= StStop;
                            nCnt  <= '0;
                            tx    <= 1'b1;
                        end
`endif
                        StStop: begin
                            nCnt <= nCnt + 3'd1;
                            tx   <= 1'b1;
                        end
                        default: begin
                            state <= StIdle;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_trans_cfg.sv
// Self-checking bench for uart_trans_cfg: frame-level reference model checked every cycle,
// plus directed frames with hand-computed bit patterns and timings.
module tb_uart_trans_cfg;

    localparam int OS = 16;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic [1:0] data_len;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx;
    logic       tx_ack;
    logic       tx_busy;
    logic       tx_done_tick;

    uart_trans_cfg #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .tx_start    (tx_start),
        .din         (din),
        .data_len    (data_len),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .tx_ack      (tx_ack),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec    = 0;
    int nErr    = 0;
    int cyc     = 0;
    int tickDiv = 1;
    int tickCnt = 0;

    // Reference model: a frame is a list of line levels, one per bit period;
    // the model only counts s_ticks since acceptance.
    logic mBusy  = 1'b0;
    int   mTicks = 0;
    logic mBits[$];
    logic mTx    = 1'b1;
    logic mAck   = 1'b0;
    logic mDone  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            if (nErr <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic buildFrame();
        int   nb;
        logic p;
        mBits.delete();
        mBits.push_back(1'b0);
        nb = int'(data_len) + 5;
        p  = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mBits.push_back(din[i]);
            p = p ^ din[i];
        end
`ifdef UART_TX_PARITY_EN
        if (parity_mode == 2'b01) mBits.push_back(p);
        if (parity_mode == 2'b10) mBits.push_back(~p);
`endif
        mBits.push_back(1'b1);
        if (stop2) mBits.push_back(1'b1);
    endtask

    task automatic modelStep();
        logic wasIdle;
        logic endNow;
        if (!reset) begin
            mBusy  = 1'b0;
            mTicks = 0;
            mAck   = 1'b0;
            mDone  = 1'b0;
            mTx    = 1'b1;
        end else begin
            wasIdle = !mBusy;
            endNow  = 1'b0;
            mAck    = 1'b0;
            mDone   = 1'b0;
            if (mBusy && s_tick) begin
                mTicks++;
                if (mTicks == mBits.size() * OS) begin
                    endNow = 1'b1;
                    mBusy  = 1'b0;
                    mDone  = 1'b1;
                end
            end
            if (tx_start && (wasIdle || endNow)) begin
                buildFrame();
                mTicks = 0;
                mBusy  = 1'b1;
                mAck   = 1'b1;
            end
            mTx = mBusy ? mBits[mTicks / OS] : 1'b1;
        end
    endtask

    task automatic step();
        s_tick  = (tickCnt == 0);
        tickCnt = (tickCnt + 1) % tickDiv;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cyc++;
        chk("tx", int'(tx), int'(mTx));
        chk("tx_ack", int'(tx_ack), int'(mAck));
        chk("tx_busy", int'(tx_busy), int'(mBusy));
        chk("tx_done_tick", int'(tx_done_tick), int'(mDone));
    endtask

    // Sample 0 is the cycle after the accept edge; bits[k] is tx mid-way through bit k.
    task automatic runFrame(input int bitCycles, input bit mutate, output logic [11:0] bits,
                            output int doneAt, output int acks);
        bits   = '0;
        doneAt = -1;
        acks   = 0;
        for (int j = 0; j < bitCycles * 14; j++) begin
            step();
            if (j == 0) tx_start = 1'b0;
            if (mutate && j == 100) begin
                din         = ~din;
                data_len    = data_len + 2'd1;
                stop2       = ~stop2;
                parity_mode = 2'b01;
            end
            if ((j % bitCycles) == bitCycles / 2 && (j / bitCycles) < 12) bits[j / bitCycles] = tx;
            if (tx_ack) acks++;
            if (tx_done_tick && doneAt < 0) doneAt = j;
            if (doneAt >= 0 && j >= doneAt + 2) break;
        end
        if (doneAt < 0) chk("frame_timeout", 0, 1);
    endtask

    logic [11:0] bits;
    int          doneAt;
    int          acks;
    int          dones;
    int          ack2At;
    int          done1At;

    initial begin
        reset       = 1'b0;
        tx_start    = 1'b0;
        din         = 8'h00;
        data_len    = 2'b00;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        s_tick      = 1'b0;
        repeat (3) step();
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(tx_busy), 0);
        reset = 1'b1;
        step();

        // 8N1, 0xA5
        din = 8'hA5; data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("a5_bits", int'(bits[9:0]), int'(10'b1101001010));
        chk("a5_done", doneAt, 160);
        chk("a5_acks", acks, 1);

`ifdef UART_TX_PARITY_EN
        din = 8'hA5; parity_mode = 2'b01; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("even_parity_bit", int'(bits[9]), 0);
        chk("even_done", doneAt, 176);
        din = 8'hA5; parity_mode = 2'b10; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("odd_parity_bit", int'(bits[9]), 1);
        chk("odd_done", doneAt, 176);
`else
        din = 8'hA5; parity_mode = 2'b01; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("noparity_bits", int'(bits[9:0]), int'(10'b1101001010));
        chk("noparity_done", doneAt, 160);
`endif

        // 7 data bits, two stop bits
        din = 8'hFF; data_len = 2'b10; parity_mode = 2'b00; stop2 = 1'b1; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("len7_bits", int'(bits[9:0]), int'(10'b1111111110));
        chk("len7_done", doneAt, 160);

        // Back-to-back frames with tx_start held high
        din = 8'h55; data_len = 2'b11; stop2 = 1'b0; tx_start = 1'b1;
        acks = 0; dones = 0; ack2At = -1; done1At = -1;
        for (int j = 0; j < 400; j++) begin
            step();
            if (j == 0) din = 8'h0F;
            if (tx_ack) begin
                acks++;
                if (acks == 2) begin
                    ack2At   = j;
                    tx_start = 1'b0;
                    chk("b2b_second_start", int'(tx), 0);
                end
            end
            if (tx_done_tick) begin
                dones++;
                if (dones == 1) done1At = j;
            end
        end
        tx_start = 1'b0;
        chk("b2b_acks", acks, 2);
        chk("b2b_dones", dones, 2);
        chk("b2b_first_done", done1At, 160);
        chk("b2b_no_gap", ack2At, done1At);

        // Reset during data bit 3
        din = 8'h3C; tx_start = 1'b1;
        for (int j = 0; j < 70; j++) begin
            step();
            if (j == 0) tx_start = 1'b0;
        end
        reset = 1'b0;
        step();
        chk("midreset_tx", int'(tx), 1);
        chk("midreset_busy", int'(tx_busy), 0);
        chk("midreset_done", int'(tx_done_tick), 0);
        reset = 1'b1;
        step();
        din = 8'h3C; tx_start = 1'b1;
        runFrame(16, 1'b0, bits, doneAt, acks);
        chk("postreset_bits", int'(bits[9:0]), int'(10'b1001111000));
        chk("postreset_done", doneAt, 160);

        // s_tick every 4 cycles, inputs changed mid-frame
        tickDiv = 4; tickCnt = 0;
        din = 8'hC3; data_len = 2'b11; parity_mode = 2'b00; stop2 = 1'b0; tx_start = 1'b1;
        runFrame(64, 1'b1, bits, doneAt, acks);
        chk("div4_bits", int'(bits[9:0]), int'(10'b1110000110));
        chk("div4_done", doneAt, 640);
        chk("div4_acks", acks, 1);

        // Randomised traffic against the model
        for (int seg = 0; seg < 60; seg++) begin
            tickDiv = $urandom_range(1, 3);
            tickCnt = 0;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 7) == 0) tx_start = ~tx_start;
                din = 8'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    data_len    = 2'($urandom);
                    parity_mode = 2'($urandom);
                    stop2       = 1'($urandom);
                end
                reset = ($urandom_range(0, 2999) != 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
